// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Optional checksum phase is built in when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_HDR,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam int unsigned HDR_BYTES  = 4;
   localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream (valid/ready) plus instruction memory write port of the loader.
// master = byte source / memory side, slave = the loader itself.
interface imem_loader_if #(
   parameter int ADDR_W = 32
);

   logic              in_valid;
   logic [7:0]        in_byte;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output in_valid,
      output in_byte,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  in_valid,
      input  in_byte,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Collects four accepted bytes into a little-endian word; word_valid pulses
// combinationally on the byte that completes the word, so the caller can register it.
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  idx;
   logic [23:0] sr;

   // Earlier bytes sit in sr with the oldest at the bottom, the newest byte goes on top.
   assign word_valid = byte_valid && (idx == 2'(WORD_BYTES - 1));
   assign word       = {byte_in, sr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         sr  <= '0;
      end else if (clear) begin
         idx <= '0;
         sr  <= '0;
      end else if (byte_valid) begin
         idx <= idx + 2'd1;
         sr  <= {byte_in, sr[23:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header word count, then N words written to instruction memory,
// core held in reset until done. IMEM_LOADER_CHECKSUM_EN adds a trailing checksum check.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned       DEPTH     = 1024,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   imem_loader_if.slave  bus,
   output logic          cpu_rst_n,
   output logic          load_done,
   output logic          load_err
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_t                 state;
   state_t                 next_state;
   logic                   accept;
   logic                   asm_clear;
   logic                   word_valid;
   logic [31:0]            asm_word;
   logic [HDR_BYTES*8-1:0] hdr_count;
   logic                   hdr_take;
   logic                   data_take;
   logic [CNT_W-1:0]       k;
   logic [CNT_W-1:0]       n_q;

   assign accept    = bus.in_valid && bus.in_ready;
   assign hdr_count = asm_word;
   assign hdr_take  = (state == S_HDR) && word_valid;
   assign data_take = (state == S_DATA) && word_valid;
   assign asm_clear = hdr_take || (state == S_DONE) || (state == S_ERR);

   byte_assembler u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (asm_clear),
      .byte_valid (accept),
      .byte_in    (bus.in_byte),
      .word_valid (word_valid),
      .word       (asm_word)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (data_take) begin
         csum <= csum + asm_word;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_HDR;
      end else begin
         state <= next_state;
      end
   end

   // The last data word finishes on its write cycle, so load_done follows the final strobe.
   always_comb begin
      next_state = state;
      unique case (state)
         S_HDR: begin
            if (word_valid) begin
               if (hdr_count == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  next_state = S_CHK;
`else
                  next_state = S_DONE;
`endif
               end else if (hdr_count > 32'(DEPTH)) begin
                  next_state = S_ERR;
               end else begin
                  next_state = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (bus.mem_we && (k == n_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               next_state = S_CHK;
`else
               next_state = S_DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (word_valid) begin
               next_state = (asm_word == csum) ? S_DONE : S_ERR;
            end
         end
`endif
         default: next_state = state;
      endcase
   end

   // Status outputs are registered from next_state so they change on the same edge as state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.in_ready  <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= BASE_ADDR;
         bus.mem_wdata <= '0;
         cpu_rst_n     <= 1'b0;
         load_done     <= 1'b0;
         load_err      <= 1'b0;
         k             <= '0;
         n_q           <= '0;
      end else begin
         bus.in_ready <= (next_state == S_HDR) || (next_state == S_DATA) ||
                         (next_state == S_CHK);
         bus.mem_we   <= data_take;
         cpu_rst_n    <= (next_state == S_DONE);
         load_done    <= (next_state == S_DONE);
         load_err     <= (next_state == S_ERR);
         if (hdr_take) begin
            n_q <= hdr_count[CNT_W-1:0];
         end
         if (data_take) begin
            bus.mem_addr  <= BASE_ADDR + ADDR_W'({k, 2'b00});
            bus.mem_wdata <= asm_word;
            k             <= k + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of randomized loads against a
// queue-based model, plus hand-written timing and reset sequences.
module tb_imem_loader;

   localparam int unsigned DEPTH     = 1024;
   localparam int          ADDR_W    = 32;
   localparam logic [31:0] BASE_ADDR = 32'h0;

   typedef struct {
      logic [31:0] n;
      int          gapPct;
      bit          badSum;
      int          expWrites;
      bit          expErr;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cpu_rst_n;
   logic load_done;
   logic load_err;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] wq[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .cpu_rst_n (cpu_rst_n),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      int t;
      t = 0;
      bus.in_valid = 1'b1;
      bus.in_byte  = b;
      while (bus.in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, t);
         bus.in_valid = 1'b0;
      end else begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic sendWord(input logic [31:0] w, input int gapPct);
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) begin
         tmp = w >> (8 * i);
         sendByte(tmp[7:0]);
         if (int'($urandom_range(99)) < gapPct) @(negedge clk);
      end
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 0);
      checkOutput("rst_mem_addr", bus.mem_addr, BASE_ADDR);
      checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
      checkOutput("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
      checkOutput("rst_load_done", 32'(load_done), 0);
      checkOutput("rst_load_err", 32'(load_err), 0);
      wq.delete();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [31:0] words[$];
      logic [31:0] sum;
      logic [31:0] w;
      int nw;
      sum = 0;
      applyReset();
      sendWord(v.n, v.gapPct);
      if (v.n <= DEPTH) begin
         for (int i = 0; i < int'(v.n); i++) begin
            w = $urandom;
            words.push_back(w);
            sum += w;
            sendWord(w, v.gapPct);
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         sendWord(v.badSum ? sum + 32'd1 : sum, v.gapPct);
`endif
      end
      repeat (3) @(negedge clk);
      checkOutput("n_writes", wq.size(), v.expWrites);
      nw = (wq.size() < words.size()) ? wq.size() : words.size();
      for (int i = 0; i < nw; i++) begin
         checkOutput("wr_addr", wq[i][63:32], BASE_ADDR + 32'(4 * i));
         checkOutput("wr_data", wq[i][31:0], words[i]);
      end
      checkOutput("end_load_done", 32'(load_done), 32'(!v.expErr));
      checkOutput("end_load_err", 32'(load_err), 32'(v.expErr));
      checkOutput("end_cpu_rst_n", 32'(cpu_rst_n), 32'(!v.expErr));
      nw = wq.size();
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'hAA;
      repeat (4) begin
         @(negedge clk);
         checkOutput("terminal_in_ready", 32'(bus.in_ready), 0);
      end
      bus.in_valid = 1'b0;
      checkOutput("terminal_no_write", wq.size(), nw);
   endtask

   initial begin
      logic [31:0] w;
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;

      vecs.push_back('{n: 32'd3,          gapPct: 0,   badSum: 1'b0, expWrites: 3,     expErr: 1'b0});
      vecs.push_back('{n: 32'd5,          gapPct: 50,  badSum: 1'b0, expWrites: 5,     expErr: 1'b0});
      vecs.push_back('{n: 32'd1,          gapPct: 100, badSum: 1'b0, expWrites: 1,     expErr: 1'b0});
      vecs.push_back('{n: 32'd17,         gapPct: 30,  badSum: 1'b0, expWrites: 17,    expErr: 1'b0});
      vecs.push_back('{n: 32'd0,          gapPct: 20,  badSum: 1'b0, expWrites: 0,     expErr: 1'b0});
      vecs.push_back('{n: DEPTH + 1,      gapPct: 0,   badSum: 1'b0, expWrites: 0,     expErr: 1'b1});
      vecs.push_back('{n: 32'hFFFF_FFFF,  gapPct: 10,  badSum: 1'b0, expWrites: 0,     expErr: 1'b1});
      vecs.push_back('{n: DEPTH,          gapPct: 0,   badSum: 1'b0, expWrites: DEPTH, expErr: 1'b0});
`ifdef IMEM_LOADER_CHECKSUM_EN
      vecs.push_back('{n: 32'd4,          gapPct: 30,  badSum: 1'b1, expWrites: 4,     expErr: 1'b1});
      vecs.push_back('{n: 32'd0,          gapPct: 0,   badSum: 1'b1, expWrites: 0,     expErr: 1'b1});
`endif

      @(negedge clk);

      // Two-word image: strobe timing and done one cycle after the last write.
      applyReset();
      sendWord(32'd2, 0);
      sendWord(32'h00A0_0513, 0);
      sendWord(32'h00B0_0593, 0);
      checkOutput("p1_we_pulse", 32'(bus.mem_we), 1);
      checkOutput("p1_addr1", bus.mem_addr, BASE_ADDR + 32'h4);
      checkOutput("p1_data1", bus.mem_wdata, 32'h00B0_0593);
      checkOutput("p1_done_in_write", 32'(load_done), 0);
      @(negedge clk);
      checkOutput("p1_we_single", 32'(bus.mem_we), 0);
      checkOutput("p1_addr_hold", bus.mem_addr, BASE_ADDR + 32'h4);
      checkOutput("p1_data_hold", bus.mem_wdata, 32'h00B0_0593);
`ifdef IMEM_LOADER_CHECKSUM_EN
      checkOutput("p1_chk_ready", 32'(bus.in_ready), 1);
      checkOutput("p1_chk_not_done", 32'(load_done), 0);
      sendWord(32'h00A0_0513 + 32'h00B0_0593, 0);
`endif
      checkOutput("p1_load_done", 32'(load_done), 1);
      checkOutput("p1_cpu_rst_n", 32'(cpu_rst_n), 1);
      checkOutput("p1_in_ready", 32'(bus.in_ready), 0);
      checkOutput("p1_n_writes", wq.size(), 2);
      if (wq.size() > 0) checkOutput("p1_first_write", wq[0][31:0], 32'h00A0_0513);

      // Empty image finishes straight after the header (or after a zero checksum).
      applyReset();
      sendWord(32'd0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      checkOutput("p2_chk_ready", 32'(bus.in_ready), 1);
      checkOutput("p2_chk_not_done", 32'(load_done), 0);
      sendWord(32'd0, 0);
`endif
      checkOutput("p2_load_done", 32'(load_done), 1);
      checkOutput("p2_cpu_rst_n", 32'(cpu_rst_n), 1);
      checkOutput("p2_no_write", wq.size(), 0);

      // Oversized header is rejected on the edge of its last byte.
      applyReset();
      sendWord(DEPTH + 1, 0);
      checkOutput("p3_load_err", 32'(load_err), 1);
      checkOutput("p3_in_ready", 32'(bus.in_ready), 0);
      checkOutput("p3_cpu_rst_n", 32'(cpu_rst_n), 0);

      // Reset in the middle of a word, then a fresh single-word load.
      applyReset();
      sendWord(32'd2, 0);
      sendWord(32'hCAFE_F00D, 0);
      sendByte(8'h11);
      sendByte(8'h22);
      rst_n = 1'b0;
      #1;
      checkOutput("p5_in_ready", 32'(bus.in_ready), 0);
      checkOutput("p5_mem_we", 32'(bus.mem_we), 0);
      checkOutput("p5_mem_addr", bus.mem_addr, BASE_ADDR);
      checkOutput("p5_mem_wdata", bus.mem_wdata, 0);
      checkOutput("p5_cpu_rst_n", 32'(cpu_rst_n), 0);
      checkOutput("p5_load_done", 32'(load_done), 0);
      @(negedge clk);
      wq.delete();
      rst_n = 1'b1;
      @(negedge clk);
      w = $urandom;
      sendWord(32'd1, 0);
      sendWord(w, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendWord(w, 0);
`endif
      repeat (2) @(negedge clk);
      checkOutput("p5_n_writes", wq.size(), 1);
      if (wq.size() > 0) begin
         checkOutput("p5_addr", wq[0][63:32], BASE_ADDR);
         checkOutput("p5_data", wq[0][31:0], w);
      end
      checkOutput("p5_load_done", 32'(load_done), 1);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and drives the instruction memory write port. It holds the RISC-V core in reset until the full image is written. It sits between the host byte link (UART receiver or testbench) and the instruction memory write side, which is the counterpart of the core's read-only fetch path.

Parameters:
DEPTH, 1024, instruction memory capacity in 32-bit words.
ADDR_W, 32, width of the byte address driven to memory.
BASE_ADDR, 0, byte address of the first loaded word; must be a multiple of 4.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  a byte is present on in_byte.
in_byte  input  8  stream byte.
in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid and in_ready are both high.
mem_we  output  1  one-cycle write strobe to instruction memory.
mem_addr  output  ADDR_W  byte address of the word being written.
mem_wdata  output  32  word being written.
cpu_rst_n  output  1  core reset; held low until the load completes.
load_done  output  1  image loaded successfully; sticky until reset.
load_err  output  1  load failed; sticky until reset.

Behaviour:
- Reset is asynchronous and active-low on rst_n, clocked on clk. All state updates on the rising edge of clk.
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst_n=0, load_done=0, load_err=0. The state machine enters S_HDR, and the byte and word counters clear.
- Stream format: a 4-byte little-endian word count N, then N data words, each little-endian (first byte goes to bits [7:0]).
- States and transitions:
  - S_HDR: in_ready=1. Assemble N from 4 bytes.
    - N==0 -> S_DONE.
    - N>DEPTH -> S_ERR.
    - Otherwise -> S_DATA.
  - S_DATA: in_ready=1. On the cycle after the 4th byte of word k is accepted:
    - mem_we=1 for exactly one cycle.
    - mem_addr=BASE_ADDR+4*k.
    - mem_wdata=the assembled word.
    - After the write of word N-1 -> S_DONE (or S_CHK, see Optional Feature).
  - S_DONE: in_ready=0, load_done=1, cpu_rst_n=1. Terminal until reset.
  - S_ERR: in_ready=0, load_err=1, cpu_rst_n=0. Terminal until reset.
- Latency: the write strobe is registered, one cycle after the last byte of a word is accepted. in_ready stays high during the write cycle; a byte accepted in that cycle starts the next word.
- The byte index wraps 0..3. The word index k is a counter sized $clog2(DEPTH)+1 bits and never exceeds N.
- in_valid low stalls assembly indefinitely. Partial-word bytes are retained across stalls.
- mem_addr and mem_wdata hold their last written values when mem_we=0.
- rst_n asserted mid-load: the load aborts immediately, all outputs return to reset values, and the next load restarts at S_HDR. Words already written are not cleared.
- Bytes offered in S_DONE or S_ERR are not accepted (in_ready=0).

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined: after the last data word, state S_CHK (in_ready=1) accepts a 4-byte little-endian checksum.
  - The checksum must equal the sum of all N data words mod 2^32. For N==0 the expected checksum is 0, and S_HDR goes to S_CHK.
  - Match -> S_DONE; mismatch -> S_ERR.
  - No mem_we is issued for checksum bytes.
- Not defined: no S_CHK state and no accumulator logic; the last data write goes straight to S_DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state encoding (S_HDR, S_DATA, S_CHK, S_DONE, S_ERR);
  - constant HDR_BYTES=4;
  - constant WORD_BYTES=4.
- One sub-module, byte_assembler:
  - shifts 4 accepted bytes into a 32-bit little-endian word;
  - emits a one-cycle word_valid;
  - has a clear input, used between the header and data phases.

Test Plan:
- Reset then header 02 00 00 00, then bytes 13 05 A0 00 and 93 05 B0 00 -> mem_we pulses twice: addr 0x0 data 0x00A00513, then addr 0x4 data 0x00B00593. load_done=1 and cpu_rst_n=1 on the cycle after the second write.
- Header 00 00 00 00 -> no mem_we; load_done=1 immediately after the 4th header byte (without the macro).
- Header for N=DEPTH+1 (0x401 with default DEPTH) -> load_err=1, cpu_rst_n stays 0, in_ready=0, no writes.
- N=1 with in_valid toggling 1/0 every cycle -> a single write of the correct word; the partial word is preserved across gaps.
- rst_n pulsed low after 2 bytes of data word 1 -> outputs return to reset values at once. A fresh N=1 load then writes to BASE_ADDR and ends with load_done.
- With IMEM_LOADER_CHECKSUM_EN: N=2 with a correct checksum -> load_done=1. Same stream with a wrong checksum (e.g. 0) -> load_err=1, cpu_rst_n=0.
